unidad_fetch: RTL and testbench
===============================

Name: unidad_fetch

Overview:
- Instruction fetch unit: the reading side of the instruction memory port (MemoriaInstrucciones).
- Holds the PC and drives the memory address; the memory returns the instruction combinationally in the same cycle.
- Each fetched word is buffered with its PC in a 2-entry queue and handed to decode over a valid/ready handshake.
- Accepts PC redirects (branch/jump) from execute and flushes stale instructions.

Parameters:
- PC_RESET, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- ADDR_LIMIT, 32'd256, first byte address outside the loaded program; fetch stops at or above it.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  fetch enable; when 0, no new fetch is pushed (queue can still drain).
- mem_addr  out  32  byte address to instruction memory; equals pc register.
- mem_inst  in  32  instruction word returned by memory for mem_addr, same cycle.
- redirect  in  1  one-cycle pulse: load new PC and flush queue.
- redirect_pc  in  32  target PC, sampled when redirect=1.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  decode accepts head this cycle when inst_valid=1.
- inst_out  out  32  instruction at queue head.
- pc_out  out  32  PC of inst_out.
- fetch_err  out  1  sticky error flag (see Optional Feature).
- out_of_range  out  1  pc >= ADDR_LIMIT; fetching stopped.

Behaviour:
- Reset (rst=1 at edge): pc=PC_RESET, count=0, both queue entries cleared, inst_out=0, pc_out=0, inst_valid=0, fetch_err=0. Reset overrides all other inputs, including mid-stall and mid-redirect.
- pop = inst_valid & inst_ready.
- push = en & !redirect & !out_of_range & !fetch_err & (count<2 | pop).
- On push: entry {pc, mem_inst} written at tail; pc <= pc + 4, wrapping modulo 2^32.
- Count update: count += push - pop. Simultaneous push and pop at count=2 is legal; count stays 2 and the PC advances.
- Latency: inst_valid is registered (count!=0).
  - First instruction is pushed on the first edge after rst falls.
  - inst_valid=1 and inst_out=mem[PC_RESET] from that point.
  - Steady streaming with inst_ready=1: 1 instruction/cycle.
- Stall (inst_ready=0): queue fills to 2 and the PC freezes at the third address. mem_addr holds, no instruction is lost, and the head and its pc_out stay stable until popped.
- Redirect (redirect=1 at edge):
  - count <= 0; any pop that cycle is discarded.
  - pc <= redirect_pc; no push that cycle.
  - inst_valid=0 for exactly one cycle; the target instruction is pushed on the next edge.
  - Clears out_of_range.
- out_of_range is combinational: pc >= ADDR_LIMIT. Already-queued instructions still drain. Recovery only via redirect or reset.
- en=0: PC holds and queue drains normally. en low together with redirect still redirects.
- Queue order strictly FIFO; pc_out always matches the address the instruction was read from.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- When defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_err=1 at that edge.
  - pc is still loaded, queue flushed, all pushes are blocked.
  - fetch_err stays 1 until rst or a redirect with aligned target (which clears it and resumes).
- When not defined:
  - redirect_pc[1:0] is forced to 00 on load.
  - fetch_err is tied to 0.

Test Plan:
- Stimulus for all scenarios: memory model returns 32'hA000_0000 | addr.
- Reset then en=1, inst_ready=1: pc_out sequence 0,4,8,…,52 on consecutive cycles; inst_out=A000_0000,A000_0004,…; inst_valid rises 1 cycle after rst falls.
- Stall: inst_ready=0 for 5 cycles after head=0x08: count=2, head stays 0x08, mem_addr holds 0x10. Release → 0x08,0x0C,0x10 in order with none skipped or repeated.
- Redirect to 0x30 while queue holds 0x14,0x18 and inst_ready=1: inst_valid=0 next cycle, then pc_out=0x30,0x34; 0x14 and 0x18 are never seen after the redirect edge.
- ADDR_LIMIT=64, run to the end: last delivered pc_out=0x3C, out_of_range=1, inst_valid falls after drain. Redirect to 0x00 restarts the stream.
- Misaligned redirect to 0x22:
  - With FETCH_MISALIGN_TRAP_EN: fetch_err=1, no further inst_valid. Then redirect to 0x20 clears fetch_err and resumes at 0x20.
  - Without the macro: fetch resumes at 0x20 and fetch_err stays 0.
- Assert rst during a stall with count=2: next cycle inst_valid=0, pc=PC_RESET, fetch_err=0.

Source files
------------

// File: rtl/unidad_fetch.sv
// Instruction fetch: PC register, 2-entry {pc, inst} queue toward decode, redirect/flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module unidad_fetch #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        fetch_err,
    output logic        out_of_range
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t [1:0] q;
    entry_t       new_e;
    logic [31:0]  pc;
    logic [1:0]   count;
    logic         err_q;
    logic         pop, push;
    logic [31:0]  tgt_pc;
    logic         tgt_bad;

    assign mem_addr     = pc;
    assign out_of_range = pc >= ADDR_LIMIT;
    assign inst_valid   = count != 2'd0;
    assign inst_out     = q[0].inst;
    assign pc_out       = q[0].pc;
    assign fetch_err    = err_q;
    assign new_e        = '{pc: pc, inst: mem_inst};

    assign pop  = inst_valid & inst_ready;
    assign push = en & ~redirect & ~out_of_range & ~err_q & ((count < 2'd2) | pop);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt_pc  = redirect_pc;
    assign tgt_bad = |redirect_pc[1:0];
`else
    assign tgt_pc  = {redirect_pc[31:2], 2'b00};
    assign tgt_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= PC_RESET;
            count <= 2'd0;
            q     <= '0;
            err_q <= 1'b0;
        end else if (redirect) begin
            // Flush discards any pop this cycle; stale entries are simply invalidated.
            pc    <= tgt_pc;
            count <= 2'd0;
            err_q <= tgt_bad;
        end else begin
            if (push)
                pc <= pc + 32'd4;
            count <= count + {1'b0, push} - {1'b0, pop};
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        q[0] <= q[1];
                        q[1] <= new_e;
                    end else begin
                        q[0] <= new_e;
                    end
                end
                2'b01: q[0] <= q[1];
                2'b10: begin
                    if (count == 2'd0)
                        q[0] <= new_e;
                    else
                        q[1] <= new_e;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_unidad_fetch.sv
// Self-checking bench for unidad_fetch: directed scenarios plus random traffic vs. a queue model.
module tb_unidad_fetch;
    localparam logic [31:0] PC_RST = 32'h0;
    localparam logic [31:0] LIMIT  = 32'd64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out, pc_out;
    logic        fetch_err, out_of_range;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural PC, queue of fetched PCs, error flag
    logic [31:0] mpc = PC_RST;
    logic [31:0] mq[$];
    logic        merr = 1'b0;

    unidad_fetch #(.PC_RESET(PC_RST), .ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .en(en), .mem_addr(mem_addr), .mem_inst(mem_inst),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_out(inst_out), .pc_out(pc_out),
        .fetch_err(fetch_err), .out_of_range(out_of_range)
    );

    assign mem_inst = 32'hA000_0000 | mem_addr;

    always #5 clk = ~clk;

    task automatic tick();
        bit do_pop, do_push;
        do_pop = (mq.size() != 0) && inst_ready;
        if (rst) begin
            mpc = PC_RST;
            mq.delete();
            merr = 1'b0;
        end else if (redirect) begin
            mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            mpc  = redirect_pc;
            merr = (redirect_pc % 4) != 0;
`else
            mpc  = redirect_pc - (redirect_pc % 4);
`endif
        end else begin
            do_push = en && (mpc < LIMIT) && !merr && (mq.size() < 2 || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b exp 0", inst_valid); end
        vectors++; if (inst_out !== 32'h0) begin miscompares++; $display("FAIL reset_inst: got %h exp 0", inst_out); end
        vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL reset_pcout: got %h exp 0", pc_out); end
        vectors++; if (mem_addr !== PC_RST) begin miscompares++; $display("FAIL reset_addr: got %h exp %h", mem_addr, PC_RST); end
        vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b exp 0", fetch_err); end
    endtask

    task automatic test_stream();
        do_reset();
        en = 1'b1; inst_ready = 1'b1;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL stream_pre: got %b exp 0", inst_valid); end
        for (int i = 0; i < 14; i++) begin
            tick();
            vectors++;
            if (inst_valid !== 1'b1 || pc_out !== 32'(4 * i) || inst_out !== (32'hA000_0000 | 32'(4 * i))) begin
                miscompares++;
                $display("FAIL stream_%0d: got v=%b pc=%h inst=%h exp v=1 pc=%h", i, inst_valid, pc_out, inst_out, 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_seq[3] = '{32'h0C, 32'h10, 32'h14};
        do_reset();
        en = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (pc_out !== 32'h08 || inst_valid !== 1'b1) begin miscompares++; $display("FAIL stall_head_%0d: got v=%b pc=%h exp 08", i, inst_valid, pc_out); end
        end
        vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL stall_addr: got %h exp 10", mem_addr); end
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (pc_out !== exp_seq[i] || inst_valid !== 1'b1) begin miscompares++; $display("FAIL stall_rel_%0d: got v=%b pc=%h exp %h", i, inst_valid, pc_out, exp_seq[i]); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        en = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        inst_ready = 1'b0;
        tick();
        vectors++; if (pc_out !== 32'h14 || mem_addr !== 32'h1C) begin miscompares++; $display("FAIL redir_setup: got pc=%h addr=%h exp 14/1c", pc_out, mem_addr); end
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h30;
        tick();
        redirect = 1'b0;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL redir_bubble: got %b exp 0", inst_valid); end
        tick();
        vectors++; if (inst_valid !== 1'b1 || pc_out !== 32'h30) begin miscompares++; $display("FAIL redir_t0: got v=%b pc=%h exp 30", inst_valid, pc_out); end
        tick();
        vectors++; if (inst_valid !== 1'b1 || pc_out !== 32'h34) begin miscompares++; $display("FAIL redir_t1: got v=%b pc=%h exp 34", inst_valid, pc_out); end
    endtask

    task automatic test_limit();
        do_reset();
        en = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        vectors++; if (pc_out !== 32'h3C || inst_valid !== 1'b1) begin miscompares++; $display("FAIL lim_last: got v=%b pc=%h exp 3c", inst_valid, pc_out); end
        vectors++; if (out_of_range !== 1'b1) begin miscompares++; $display("FAIL lim_oor: got %b exp 1", out_of_range); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (inst_valid !== 1'b0 || out_of_range !== 1'b1) begin miscompares++; $display("FAIL lim_drain_%0d: got v=%b oor=%b exp 0/1", i, inst_valid, out_of_range); end
        end
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        vectors++; if (out_of_range !== 1'b0 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL lim_redir: got oor=%b v=%b exp 0/0", out_of_range, inst_valid); end
        tick();
        vectors++; if (inst_valid !== 1'b1 || pc_out !== 32'h0) begin miscompares++; $display("FAIL lim_restart: got v=%b pc=%h exp 0", inst_valid, pc_out); end
    endtask

    task automatic test_misalign();
        do_reset();
        en = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        redirect = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        vectors++; if (fetch_err !== 1'b1 || mem_addr !== 32'h22) begin miscompares++; $display("FAIL mis_trap: got err=%b addr=%h exp 1/22", fetch_err, mem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (inst_valid !== 1'b0 || fetch_err !== 1'b1) begin miscompares++; $display("FAIL mis_hold_%0d: got v=%b err=%b exp 0/1", i, inst_valid, fetch_err); end
        end
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL mis_clear: got %b exp 0", fetch_err); end
`else
        vectors++; if (fetch_err !== 1'b0 || mem_addr !== 32'h20) begin miscompares++; $display("FAIL mis_align: got err=%b addr=%h exp 0/20", fetch_err, mem_addr); end
`endif
        tick();
        vectors++; if (inst_valid !== 1'b1 || pc_out !== 32'h20 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL mis_resume: got v=%b pc=%h err=%b exp 1/20/0", inst_valid, pc_out, fetch_err); end
    endtask

    task automatic test_reset_stall();
        do_reset();
        en = 1'b1; inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (mem_addr !== 32'h08) begin miscompares++; $display("FAIL rs_full: got addr=%h exp 08", mem_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (inst_valid !== 1'b0 || mem_addr !== PC_RST || fetch_err !== 1'b0) begin miscompares++; $display("FAIL rs_reset: got v=%b addr=%h err=%b exp 0/%h/0", inst_valid, mem_addr, fetch_err, PC_RST); end
    endtask

    task automatic test_random();
        bit exp_v;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 99) < 1);
            en          = ($urandom_range(0, 99) < 75);
            inst_ready  = ($urandom_range(0, 99) < 60);
            redirect    = ($urandom_range(0, 99) < 8);
            redirect_pc = 32'($urandom_range(0, 20)) * 4;
            if ($urandom_range(0, 9) == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
            tick();
            exp_v = (mq.size() != 0);
            vectors++; if (inst_valid !== exp_v) begin miscompares++; $display("FAIL rnd_valid_%0d: got %b exp %b", c, inst_valid, exp_v); end
            vectors++; if (mem_addr !== mpc || out_of_range !== (mpc >= LIMIT)) begin miscompares++; $display("FAIL rnd_pc_%0d: got addr=%h oor=%b exp %h", c, mem_addr, out_of_range, mpc); end
            vectors++; if (fetch_err !== merr) begin miscompares++; $display("FAIL rnd_err_%0d: got %b exp %b", c, fetch_err, merr); end
            if (exp_v) begin
                vectors++;
                if (pc_out !== mq[0] || inst_out !== (32'hA000_0000 | mq[0])) begin
                    miscompares++;
                    $display("FAIL rnd_head_%0d: got pc=%h inst=%h exp pc=%h", c, pc_out, inst_out, mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_limit();
        test_misalign();
        test_reset_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
